// File: rtl/dp_dmi_bus_master_if.sv
// ---------------------------------------------------------------------------
// dp_dmi_bus_master_if
//
// Debug-module request/acknowledge bus between the DMI bus master and the
// debug module.
//
//   req    master -> slave  request, held until ack
//   we     master -> slave  1 write, 0 read; stable while req
//   addr   master -> slave  address (ABITS); stable while req
//   wdata  master -> slave  write data (DBITS); stable while req
//   ack    slave -> master  one-cycle acknowledge, ignored while req=0
//   rdata  slave -> master  read data (DBITS), valid with ack
//   err    slave -> master  bus error, valid with ack
// ---------------------------------------------------------------------------
interface dp_dmi_bus_master_if #(
  parameter int ABITS = 7,
  parameter int DBITS = 32
) ();

  logic             req;
  logic             we;
  logic [ABITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             ack;
  logic [DBITS-1:0] rdata;
  logic             err;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata,
    output err
  );

endinterface

// File: rtl/dp_dmi_bus_master.sv
// ---------------------------------------------------------------------------
// dp_dmi_bus_master
//
// Runs the read/write described by the DMI data register (latched at
// Update-DR) on the debug module request/acknowledge bus and returns
// {data, status} for the next Capture-DR. Keeps RISC-V style sticky status
// (busy / failed) and aborts a transaction that goes unacknowledged for
// 2**TMO_W-1 cycles.
//
// Ports
//   iclk        clock, rising edge
//   irst        asynchronous reset, active-high
//   dmi_upd     one-cycle pulse: DMI register updated
//   dmi_op      0 nop, 1 read, 2 write, 3 reserved
//   dmi_addr    request address (ABITS)
//   dmi_wdata   request write data (DBITS)
//   dmi_reset   one-cycle pulse: clear sticky status
//   dmi_hreset  one-cycle pulse: abort transaction and clear all status
//   dm          request/acknowledge bus (master side)
//   rsp_data    captured read data
//   rsp_op      0 ok, 2 failed, 3 busy (sticky)
//   busy        transaction in flight
// ---------------------------------------------------------------------------
module dp_dmi_bus_master #(
  parameter int ABITS = 7,
  parameter int DBITS = 32,
  parameter int TMO_W = 8
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                dmi_upd,
  input  logic [1:0]          dmi_op,
  input  logic [ABITS-1:0]    dmi_addr,
  input  logic [DBITS-1:0]    dmi_wdata,
  input  logic                dmi_reset,
  input  logic                dmi_hreset,
  dp_dmi_bus_master_if.master dm,
  output logic [DBITS-1:0]    rsp_data,
  output logic [1:0]          rsp_op,
  output logic                busy
);

  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [1:0] RSP_OK     = 2'd0;
  localparam logic [1:0] RSP_FAILED = 2'd2;
  localparam logic [1:0] RSP_BUSY   = 2'd3;

  // The counter starts at 0 on the first REQ cycle; when an unacknowledged
  // cycle would step it to all-ones the transaction is abandoned, giving
  // exactly 2**TMO_W-1 cycles of dm.req.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  state_t           state_reg, state_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             we_reg, we_next;
  logic [ABITS-1:0] addr_reg, addr_next;
  logic [DBITS-1:0] wdata_reg, wdata_next;
  logic [DBITS-1:0] rsp_data_reg, rsp_data_next;
  logic [1:0]       rsp_op_reg, rsp_op_next;

  logic             cmd_is_rw;
  logic             fail_evt;
  logic             busy_evt;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_reg    <= ST_IDLE;
      tmo_cnt_reg  <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rsp_data_reg <= '0;
      rsp_op_reg   <= RSP_OK;
    end else begin
      state_reg    <= state_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rsp_data_reg <= rsp_data_next;
      rsp_op_reg   <= rsp_op_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rsp_data_next = rsp_data_reg;
    rsp_op_next   = rsp_op_reg;
    fail_evt      = 1'b0;
    busy_evt      = 1'b0;
    cmd_is_rw     = (dmi_op == OP_READ) || (dmi_op == OP_WRITE);

    unique case (state_reg)
      ST_IDLE: begin
        // Any sticky status blocks new commands until dmi_reset.
        if (dmi_upd && cmd_is_rw && (rsp_op_reg == RSP_OK)) begin
          state_next   = ST_REQ;
          we_next      = (dmi_op == OP_WRITE);
          addr_next    = dmi_addr;
          wdata_next   = dmi_wdata;
          tmo_cnt_next = '0;
        end
      end

      ST_REQ: begin
        if (dm.ack) begin
          state_next = ST_IDLE;
          if (dm.err) begin
            fail_evt = 1'b1;
          end else if (!we_reg) begin
            rsp_data_next = dm.rdata;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next   = ST_IDLE;
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
          fail_evt     = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end

        // A command arriving while one is in flight is dropped and flagged,
        // even when the in-flight one completes in this same cycle.
        if (dmi_upd) begin
          busy_evt = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Sticky status: only the first event after a clear is recorded, and
    // busy wins over a simultaneous failure.
    if (rsp_op_reg == RSP_OK) begin
      if (busy_evt) begin
        rsp_op_next = RSP_BUSY;
      end else if (fail_evt) begin
        rsp_op_next = RSP_FAILED;
      end
    end

    if (dmi_reset) begin
      rsp_op_next = RSP_OK;
    end

    // Hard reset abandons the transaction and any same-cycle command or
    // acknowledge; captured read data survives.
    if (dmi_hreset) begin
      state_next    = ST_IDLE;
      tmo_cnt_next  = '0;
      rsp_op_next   = RSP_OK;
      we_next       = we_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      rsp_data_next = rsp_data_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // -------------------------------------------------------------------------
  assign dm.req   = (state_reg == ST_REQ);
  assign dm.we    = we_reg;
  assign dm.addr  = addr_reg;
  assign dm.wdata = wdata_reg;

  assign rsp_data = rsp_data_reg;
  assign rsp_op   = rsp_op_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dp_dmi_bus_master.sv
// ---------------------------------------------------------------------------
// tb_dp_dmi_bus_master
//
// Transaction-level reference model + scoreboard for dp_dmi_bus_master.
// A bus responder answers requests with random (or directed) latency, the
// model predicts status and issued commands, and a negedge monitor pops the
// expected command when dm.req rises and the expected response when busy
// falls.
// ---------------------------------------------------------------------------
module tb_dp_dmi_bus_master;

  localparam int ABITS     = 7;
  localparam int DBITS     = 32;
  localparam int TMO_W     = 4;
  localparam int TMO_LIMIT = (1 << TMO_W) - 1;

  logic             iclk       = 1'b0;
  logic             irst       = 1'b1;
  logic             dmi_upd    = 1'b0;
  logic [1:0]       dmi_op     = 2'd0;
  logic [ABITS-1:0] dmi_addr   = '0;
  logic [DBITS-1:0] dmi_wdata  = '0;
  logic             dmi_reset  = 1'b0;
  logic             dmi_hreset = 1'b0;
  logic [DBITS-1:0] rsp_data;
  logic [1:0]       rsp_op;
  logic             busy;

  dp_dmi_bus_master_if #(.ABITS(ABITS), .DBITS(DBITS)) dm_bus ();

  dp_dmi_bus_master #(.ABITS(ABITS), .DBITS(DBITS), .TMO_W(TMO_W)) dut (
    .iclk       (iclk),
    .irst       (irst),
    .dmi_upd    (dmi_upd),
    .dmi_op     (dmi_op),
    .dmi_addr   (dmi_addr),
    .dmi_wdata  (dmi_wdata),
    .dmi_reset  (dmi_reset),
    .dmi_hreset (dmi_hreset),
    .dm         (dm_bus),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .busy       (busy)
  );

  always #5 iclk = ~iclk;

  // -------------------------------------------------------------------------
  // Check bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Reference model (transaction level)
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic             we;
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [DBITS-1:0] data;
    logic [1:0]       op;
  } rsp_t;

  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];

  bit               m_busy     = 1'b0;
  int               m_age      = 0;     // unacknowledged cycles so far
  cmd_t             m_cmd      = '0;
  logic [DBITS-1:0] m_rsp_data = '0;
  logic [1:0]       m_rsp_op   = 2'd0;

  task automatic push_rsp();
    rsp_t r;
    r.data = m_rsp_data;
    r.op   = m_rsp_op;
    exp_rsp_q.push_back(r);
  endtask

  // One clock of behaviour, using the inputs as they were just before the edge.
  task automatic model_step();
    bit start, done, fail_ev, busy_ev;
    start = 0; done = 0; fail_ev = 0; busy_ev = 0;
    if (dmi_hreset) begin
      m_rsp_op = 2'd0;
      if (m_busy) begin
        m_busy = 0;
        push_rsp();
      end
      m_age = 0;
      return;
    end
    if (!m_busy) begin
      if (dmi_upd && (dmi_op == 2'd1 || dmi_op == 2'd2) && m_rsp_op == 2'd0) start = 1;
    end else begin
      if (dm_bus.ack) begin
        done = 1;
        if (dm_bus.err) fail_ev = 1;
        else if (!m_cmd.we) m_rsp_data = dm_bus.rdata;
      end else begin
        m_age++;
        if (m_age == TMO_LIMIT) begin
          done    = 1;
          fail_ev = 1;
        end
      end
      if (dmi_upd) busy_ev = 1;
    end
    if (m_rsp_op == 2'd0) begin
      if (busy_ev) m_rsp_op = 2'd3;
      else if (fail_ev) m_rsp_op = 2'd2;
    end
    if (dmi_reset) m_rsp_op = 2'd0;
    if (start) begin
      m_busy = 1;
      m_age  = 0;
      m_cmd.we    = (dmi_op == 2'd2);
      m_cmd.addr  = dmi_addr;
      m_cmd.wdata = dmi_wdata;
      exp_cmd_q.push_back(m_cmd);
    end
    if (done) begin
      m_busy = 0;
      push_rsp();
    end
  endtask

  initial begin
    forever begin
      @(posedge iclk or posedge irst);
      if (irst) begin
        m_rsp_data = '0;
        m_rsp_op   = 2'd0;
        if (m_busy) begin
          m_busy = 0;
          push_rsp();
        end
        m_age = 0;
        m_cmd = '0;
      end else begin
        model_step();
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bus responder
  // -------------------------------------------------------------------------
  int               rsp_dly_mode  = -1;  // -1 random, -2 never ack, >=0 fixed
  int               rsp_err_mode  = -1;  // -1 random, 0/1 forced
  bit               use_fix_rdata = 1'b0;
  logic [DBITS-1:0] fix_rdata     = '0;

  function automatic int pick_delay();
    int r;
    if (rsp_dly_mode == -2) return -1;
    if (rsp_dly_mode >= 0) return rsp_dly_mode;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 4);
    if (r < 9) return -1;
    return $urandom_range(10, 20);
  endfunction

  initial begin
    bit seen = 1'b0;
    int cnt  = 0;
    dm_bus.ack   = 1'b0;
    dm_bus.rdata = '0;
    dm_bus.err   = 1'b0;
    forever begin
      @(posedge iclk);
      #1;
      dm_bus.ack   = 1'b0;
      dm_bus.err   = 1'b0;
      dm_bus.rdata = $urandom;
      if (dm_bus.req && !irst) begin
        if (!seen) begin
          seen = 1'b1;
          cnt  = pick_delay();
        end
        if (cnt == 0) begin
          dm_bus.ack   = 1'b1;
          dm_bus.rdata = use_fix_rdata ? fix_rdata : $urandom;
          dm_bus.err   = (rsp_err_mode < 0) ? ($urandom_range(0, 5) == 0) : (rsp_err_mode != 0);
          seen = 1'b0;
        end else if (cnt > 0) begin
          cnt--;
        end
      end else begin
        seen = 1'b0;
        // Stray acknowledges while idle must be ignored by the DUT.
        if ($urandom_range(0, 19) == 0) begin
          dm_bus.ack = 1'b1;
          dm_bus.err = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  int req_rises    = 0;
  int last_req_len = 0;

  initial begin
    bit   prev_req  = 1'b0;
    bit   prev_busy = 1'b0;
    int   req_len   = 0;
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge iclk);
      check("busy", 64'(busy), 64'(m_busy));
      check("dm_req", 64'(dm_bus.req), 64'(m_busy));
      check("rsp_op", 64'(rsp_op), 64'(m_rsp_op));
      check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
      if (dm_bus.req && !prev_req) begin
        req_rises++;
        req_len = 0;
        check("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'(1));
        if (exp_cmd_q.size() != 0) begin
          c = exp_cmd_q.pop_front();
          check("cmd_we", 64'(dm_bus.we), 64'(c.we));
          check("cmd_addr", 64'(dm_bus.addr), 64'(c.addr));
          check("cmd_wdata", 64'(dm_bus.wdata), 64'(c.wdata));
          $display("cmd  we=%0d addr=0x%0h wdata=0x%0h", c.we, c.addr, c.wdata);
        end
      end else if (dm_bus.req) begin
        check("bus_stable", 64'({dm_bus.we, dm_bus.addr, dm_bus.wdata}),
              64'({m_cmd.we, m_cmd.addr, m_cmd.wdata}));
      end
      if (dm_bus.req) req_len++;
      if (!dm_bus.req && prev_req) last_req_len = req_len;
      if (!busy && prev_busy) begin
        check("rsp_expected", 64'(exp_rsp_q.size() != 0), 64'(1));
        if (exp_rsp_q.size() != 0) begin
          r = exp_rsp_q.pop_front();
          check("rsp_done_data", 64'(rsp_data), 64'(r.data));
          check("rsp_done_op", 64'(rsp_op), 64'(r.op));
          $display("rsp  data=0x%0h op=%0d req_cycles=%0d", r.data, r.op, req_len);
        end
      end
      prev_req  = dm_bus.req;
      prev_busy = busy;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
    dmi_upd   = 1'b1;
    dmi_op    = op;
    dmi_addr  = a;
    dmi_wdata = d;
    step();
    dmi_upd   = 1'b0;
  endtask

  task automatic pulse_reset();
    dmi_reset = 1'b1;
    step();
    dmi_reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) step();
    check("wait_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int r0;

    // Reset state
    step(); step(); step();
    check("rst_req", 64'(dm_bus.req), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp", 64'({rsp_data, rsp_op}), 64'(0));
    check("rst_bus", 64'({dm_bus.we, dm_bus.addr, dm_bus.wdata}), 64'(0));
    irst = 1'b0;
    step();

    // 1. Read, ack after two waits
    rsp_dly_mode = 2; rsp_err_mode = 0; use_fix_rdata = 1'b1; fix_rdata = 32'hDEADBEEF;
    issue(2'd1, 7'h10, 32'h0);
    wait_idle(40); step();
    check("t1_req_len", 64'(last_req_len), 64'(3));
    check("t1_rdata", 64'(rsp_data), 64'(32'hDEADBEEF));
    check("t1_op", 64'(rsp_op), 64'(0));

    // 2. Write, immediate ack
    rsp_dly_mode = 0;
    issue(2'd2, 7'h04, 32'h12345678);
    wait_idle(40); step();
    check("t2_req_len", 64'(last_req_len), 64'(1));
    check("t2_op", 64'(rsp_op), 64'(0));
    check("t2_rdata_kept", 64'(rsp_data), 64'(32'hDEADBEEF));

    // 3. Busy: second command while in REQ is dropped
    rsp_dly_mode = 5;
    r0 = req_rises;
    issue(2'd1, 7'h20, 32'h0);
    step();
    issue(2'd2, 7'h30, 32'hAAAA5555);
    wait_idle(40); step();
    check("t3_op_busy", 64'(rsp_op), 64'(3));
    check("t3_one_cmd", 64'(req_rises - r0), 64'(1));
    pulse_reset();
    check("t3_op_clr", 64'(rsp_op), 64'(0));

    // 4. Timeout, then blocked until dmi_reset
    rsp_dly_mode = -2;
    issue(2'd1, 7'h11, 32'h0);
    wait_idle(40); step();
    check("t4_req_len", 64'(last_req_len), 64'(TMO_LIMIT));
    check("t4_op_fail", 64'(rsp_op), 64'(2));
    r0 = req_rises;
    issue(2'd1, 7'h12, 32'h0);
    step(); step();
    check("t4_blocked_busy", 64'(busy), 64'(0));
    check("t4_blocked_cmd", 64'(req_rises - r0), 64'(0));
    pulse_reset();
    check("t4_op_clr", 64'(rsp_op), 64'(0));

    // 5. Bus error on a read
    rsp_dly_mode = 1; rsp_err_mode = 1;
    issue(2'd1, 7'h13, 32'h0);
    wait_idle(40); step();
    check("t5_op_fail", 64'(rsp_op), 64'(2));
    check("t5_rdata_kept", 64'(rsp_data), 64'(32'hDEADBEEF));
    pulse_reset();

    // 6a. Hard reset mid-REQ with sticky busy set
    rsp_dly_mode = -2; rsp_err_mode = 0;
    issue(2'd1, 7'h14, 32'h0);
    step();
    issue(2'd0, 7'h00, 32'h0);
    check("t6_op_busy", 64'(rsp_op), 64'(3));
    dmi_hreset = 1'b1;
    step();
    dmi_hreset = 1'b0;
    check("t6_hr_req", 64'(dm_bus.req), 64'(0));
    check("t6_hr_busy", 64'(busy), 64'(0));
    check("t6_hr_op", 64'(rsp_op), 64'(0));
    check("t6_hr_rdata", 64'(rsp_data), 64'(32'hDEADBEEF));
    step();

    // 6b. Asynchronous reset mid-REQ
    issue(2'd1, 7'h15, 32'h0);
    step();
    @(posedge iclk);
    #3;
    irst = 1'b1;
    #1;
    check("t6_irst_req", 64'(dm_bus.req), 64'(0));
    check("t6_irst_busy", 64'(busy), 64'(0));
    check("t6_irst_rsp", 64'({rsp_data, rsp_op}), 64'(0));
    check("t6_irst_bus", 64'({dm_bus.we, dm_bus.addr, dm_bus.wdata}), 64'(0));
    step();
    irst = 1'b0;
    step();

    // Randomised traffic
    rsp_dly_mode = -1; rsp_err_mode = -1; use_fix_rdata = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      dmi_upd    = ($urandom_range(0, 3) == 0);
      dmi_op     = 2'($urandom_range(0, 3));
      dmi_addr   = ABITS'($urandom);
      dmi_wdata  = $urandom;
      dmi_reset  = ($urandom_range(0, 24) == 0);
      dmi_hreset = ($urandom_range(0, 79) == 0);
      step();
    end
    dmi_upd = 1'b0; dmi_reset = 1'b0; dmi_hreset = 1'b0;
    wait_idle(40);
    step(); step();
    check("cmd_q_drained", 64'(exp_cmd_q.size()), 64'(0));
    check("rsp_q_drained", 64'(exp_rsp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
